// File: rtl/lake_arb_pkg.sv
// Shared types and constants for the lake memory arbiter and its read response buffers.
package lake_arb_pkg;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_t;

  localparam int RESP_DEPTH = 2;

endpackage

// File: rtl/lake_resp_fifo.sv
// Per-read-port response buffer: small FIFO holding SRAM read data until the requester accepts it.
module lake_resp_fifo
  import lake_arb_pkg::*;
#(
  parameter  int DATA_WIDTH = 16,
  localparam int CNT_W      = $clog2(RESP_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]      occ
);

  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [RESP_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(RESP_DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  // Valid is masked during flush so nothing can be consumed while the buffer is being cleared.
  assign out_valid = (count != '0) & ~flush;
  assign out_data  = mem_q[rd_ptr];
  assign occ       = count;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/lake_mem_arbiter.sv
// Arbitrates NUM_W write and NUM_R read requesters onto one single-port SRAM,
// buffering read responses per port so each read port sees in-order data.
module lake_mem_arbiter
  import lake_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 9,
  parameter int NUM_W      = 2,
  parameter int NUM_R      = 2
) (
  input  logic                        clk,
  input  logic                        flush,
  input  logic                        cfg_mode,
  input  logic [NUM_W*ADDR_WIDTH-1:0] w_addr,
  input  logic [NUM_W*DATA_WIDTH-1:0] w_data,
  input  logic [NUM_W-1:0]            w_valid,
  output logic [NUM_W-1:0]            w_ready,
  input  logic [NUM_R*ADDR_WIDTH-1:0] r_addr,
  input  logic [NUM_R-1:0]            r_addr_valid,
  output logic [NUM_R-1:0]            r_addr_ready,
  output logic [NUM_R*DATA_WIDTH-1:0] r_data,
  output logic [NUM_R-1:0]            r_data_valid,
  input  logic [NUM_R-1:0]            r_data_ready,
  output logic                        mem_cen,
  output logic                        mem_wen,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  output logic [DATA_WIDTH-1:0]       mem_wdata,
  input  logic [DATA_WIDTH-1:0]       mem_rdata
);

  localparam int NUM_REQ = NUM_W + NUM_R;
  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int RP_W    = (NUM_R > 1) ? $clog2(NUM_R) : 1;
  localparam int CNT_W   = $clog2(RESP_DEPTH + 1);

  arb_mode_t         mode;
  logic [IDX_W-1:0]  rr_ptr;
  logic [NUM_REQ-1:0] req;
  logic              gnt_vld;
  logic [IDX_W-1:0]  gnt_idx;
  logic              rd_gnt;
  logic [RP_W-1:0]   rd_port;
  logic [NUM_R-1:0]  r_elig;
  logic [NUM_R-1:0]  r_pop;
  logic [NUM_R-1:0]  r_push;
  logic [CNT_W-1:0]  r_occ [NUM_R];
  logic              inflight_vld_p1;
  logic [RP_W-1:0]   inflight_port_p1;
  int                cand;

  assign mode = arb_mode_t'(cfg_mode);

  // Room check counts the read landing this cycle and credits a same-cycle pop.
  function automatic logic has_room(input logic [CNT_W-1:0] occ_v, input logic infl, input logic pop_v);
    logic [CNT_W:0] lvl;
    lvl = {1'b0, occ_v} + {{CNT_W{1'b0}}, infl} - {{CNT_W{1'b0}}, pop_v};
    return lvl < (CNT_W+1)'(RESP_DEPTH);
  endfunction

  always_comb begin
    r_elig = '0;
    r_push = '0;
    req    = '0;
    for (int j = 0; j < NUM_R; j++) begin
      r_push[j] = inflight_vld_p1 && (inflight_port_p1 == RP_W'(j));
      r_elig[j] = has_room(r_occ[j], r_push[j], r_pop[j]);
    end
    for (int i = 0; i < NUM_W; i++) req[i] = w_valid[i] & ~flush;
    for (int j = 0; j < NUM_R; j++) req[NUM_W + j] = r_addr_valid[j] & r_elig[j] & ~flush;
  end

  assign r_pop = r_data_valid & r_data_ready;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (mode == ARB_FIXED) ? k : int'(rr_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!gnt_vld && req[IDX_W'(cand)]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    mem_cen      = 1'b0;
    mem_wen      = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    w_ready      = '0;
    r_addr_ready = '0;
    rd_gnt       = 1'b0;
    rd_port      = '0;
    for (int i = 0; i < NUM_W; i++) begin
      if (gnt_vld && gnt_idx == IDX_W'(i)) begin
        mem_cen    = 1'b1;
        mem_wen    = 1'b1;
        mem_addr   = w_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        mem_wdata  = w_data[i*DATA_WIDTH +: DATA_WIDTH];
        w_ready[i] = 1'b1;
      end
    end
    for (int j = 0; j < NUM_R; j++) begin
      if (gnt_vld && gnt_idx == IDX_W'(NUM_W + j)) begin
        mem_cen         = 1'b1;
        mem_addr        = r_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
        r_addr_ready[j] = 1'b1;
        rd_gnt          = 1'b1;
        rd_port         = RP_W'(j);
      end
    end
  end

  // p0 -> p1: grant cycle to SRAM data-return cycle
  always_ff @(posedge clk) begin
    if (flush) begin
      rr_ptr          <= '0;
      inflight_vld_p1 <= 1'b0;
    end else begin
      inflight_vld_p1 <= rd_gnt;
      if (gnt_vld && mode == ARB_RR)
        rr_ptr <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_gnt) inflight_port_p1 <= rd_port;
  end

  for (genvar j = 0; j < NUM_R; j++) begin : g_resp
    lake_resp_fifo #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
      .clk       (clk),
      .flush     (flush),
      .push      (r_push[j]),
      .push_data (mem_rdata),
      .out_ready (r_data_ready[j]),
      .out_valid (r_data_valid[j]),
      .out_data  (r_data[j*DATA_WIDTH +: DATA_WIDTH]),
      .occ       (r_occ[j])
    );
  end

endmodule

// File: tb/tb_lake_mem_arbiter.sv
// Directed and random stimulus for lake_mem_arbiter with an SRAM model and per-port response scoreboard.
module tb_lake_mem_arbiter;

  localparam int DW = 16;
  localparam int AW = 9;
  localparam int NW = 2;
  localparam int NR = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             flush;
  logic             cfg_mode;
  logic [NW*AW-1:0] w_addr;
  logic [NW*DW-1:0] w_data;
  logic [NW-1:0]    w_valid;
  logic [NW-1:0]    w_ready;
  logic [NR*AW-1:0] r_addr;
  logic [NR-1:0]    r_addr_valid;
  logic [NR-1:0]    r_addr_ready;
  logic [NR*DW-1:0] r_data;
  logic [NR-1:0]    r_data_valid;
  logic [NR-1:0]    r_data_ready;
  logic             mem_cen;
  logic             mem_wen;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata;
  logic [DW-1:0]    mem_rdata;

  lake_mem_arbiter #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_W      (NW),
    .NUM_R      (NR)
  ) dut (
    .clk          (clk),
    .flush        (flush),
    .cfg_mode     (cfg_mode),
    .w_addr       (w_addr),
    .w_data       (w_data),
    .w_valid      (w_valid),
    .w_ready      (w_ready),
    .r_addr       (r_addr),
    .r_addr_valid (r_addr_valid),
    .r_addr_ready (r_addr_ready),
    .r_data       (r_data),
    .r_data_valid (r_data_valid),
    .r_data_ready (r_data_ready),
    .mem_cen      (mem_cen),
    .mem_wen      (mem_wen),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  logic [DW-1:0] sram   [1<<AW];
  logic [DW-1:0] shadow [1<<AW];
  logic [DW-1:0] exp_q0 [$];
  logic [DW-1:0] exp_q1 [$];
  int            gnt_log [$];
  int            rsp_cnt [NR];
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // SRAM model: read data valid exactly one cycle after the command, junk otherwise.
  always @(posedge clk) begin
    if (mem_cen && mem_wen) sram[mem_addr] <= mem_wdata;
    if (mem_cen && !mem_wen) mem_rdata <= sram[mem_addr];
    else                     mem_rdata <= DW'($urandom);
  end

  always @(negedge clk) begin
    if (flush) begin
      chk("flush_ready", 32'({w_ready, r_addr_ready}), 0);
      chk("flush_rvalid", 32'(r_data_valid), 0);
      chk("flush_cen", 32'(mem_cen), 0);
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      chk("one_grant", 32'($countones({w_ready, r_addr_ready}) <= 1), 1);
      chk("cen_vs_hs", 32'(mem_cen), 32'((|(w_ready & w_valid)) | (|(r_addr_ready & r_addr_valid))));
      for (int i = 0; i < NW; i++) begin
        if (w_valid[i] && w_ready[i]) begin
          chk("w_cmd", {mem_wen, mem_addr, mem_wdata}, {1'b1, w_addr[i*AW +: AW], w_data[i*DW +: DW]});
          shadow[w_addr[i*AW +: AW]] = w_data[i*DW +: DW];
          gnt_log.push_back(i);
        end
      end
      for (int j = 0; j < NR; j++) begin
        if (r_addr_valid[j] && r_addr_ready[j]) begin
          chk("r_cmd", {mem_wen, mem_addr}, {1'b0, r_addr[j*AW +: AW]});
          if (j == 0) exp_q0.push_back(shadow[r_addr[j*AW +: AW]]);
          else        exp_q1.push_back(shadow[r_addr[j*AW +: AW]]);
          gnt_log.push_back(NW + j);
        end
      end
      for (int j = 0; j < NR; j++) begin
        if (r_data_valid[j] && r_data_ready[j]) begin
          rsp_cnt[j]++;
          if (j == 0) begin
            if (exp_q0.size() == 0) chk("r0_unexpected", 1, 0);
            else chk("r0_data", 32'(r_data[0 +: DW]), 32'(exp_q0.pop_front()));
          end else begin
            if (exp_q1.size() == 0) chk("r1_unexpected", 1, 0);
            else chk("r1_data", 32'(r_data[DW +: DW]), 32'(exp_q1.pop_front()));
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int p, input int a, input int d);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    w_addr[p*AW +: AW] = AW'(a);
    w_data[p*DW +: DW] = DW'(d);
    w_valid[p] = 1'b1;
    while (!ok && n < 50) begin
      @(negedge clk);
      if (w_ready[p]) ok = 1'b1;
      n++;
      @(posedge clk);
      #1;
    end
    w_valid[p] = 1'b0;
    chk("w_hs_timeout", 32'(ok), 1);
  endtask

  task automatic do_read(input int p, input int a, input bit chk_lat);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    r_addr[p*AW +: AW] = AW'(a);
    r_addr_valid[p] = 1'b1;
    while (!ok && n < 50) begin
      @(negedge clk);
      if (r_addr_ready[p]) ok = 1'b1;
      n++;
      @(posedge clk);
      #1;
    end
    r_addr_valid[p] = 1'b0;
    chk("r_hs_timeout", 32'(ok), 1);
    if (chk_lat && ok) begin
      @(negedge clk);
      chk("lat_n1", 32'(r_data_valid[p]), 0);
      @(negedge clk);
      chk("lat_n2", 32'(r_data_valid[p]), 1);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ngr;
    int n;
    int bad;
    int r0_before;
    bit hs;
    for (int a = 0; a < (1 << AW); a++) begin
      sram[a]   = '0;
      shadow[a] = '0;
    end
    rsp_cnt[0]   = 0;
    rsp_cnt[1]   = 0;
    mem_rdata    = '0;
    flush        = 1'b1;
    cfg_mode     = 1'b0;
    w_addr       = {AW'(101), AW'(100)};
    w_data       = {DW'(16'h5555), DW'(16'hAAAA)};
    r_addr       = {AW'(101), AW'(100)};
    w_valid      = '1;
    r_addr_valid = '1;
    r_data_ready = '1;

    // Reset with everything requesting, then round-robin order from pointer 0.
    repeat (3) tick();
    gnt_log.delete();
    flush = 1'b0;
    repeat (8) tick();
    w_valid      = '0;
    r_addr_valid = '0;
    chk("rr_log_size", 32'(gnt_log.size()), 8);
    for (int k = 0; k < 8; k++)
      chk("rr_order", (gnt_log.size() > k) ? 32'(gnt_log[k]) : 32'hFFFF_FFFF, 32'(k % 4));
    repeat (3) tick();

    // Write 2*i to 0..15 through w0, read back through r0 with latency checks.
    for (int i = 0; i < 16; i++) do_write(0, i, 2 * i);
    r0_before = rsp_cnt[0];
    for (int i = 0; i < 16; i++) do_read(0, i, 1'b1);
    repeat (2) tick();
    chk("seq_rsp_cnt", 32'(rsp_cnt[0] - r0_before), 16);
    chk("seq_q_empty", 32'(exp_q0.size()), 0);

    // Fixed priority: w0 always beats r0.
    cfg_mode = 1'b1;
    w_addr[0 +: AW] = AW'(300);
    w_data[0 +: DW] = DW'(16'h0BEE);
    r_addr[0 +: AW] = AW'(5);
    w_valid[0]      = 1'b1;
    r_addr_valid[0] = 1'b1;
    gnt_log.delete();
    repeat (20) tick();
    bad = 0;
    foreach (gnt_log[k]) if (gnt_log[k] != 0) bad++;
    chk("fixed_log_size", 32'(gnt_log.size()), 20);
    chk("fixed_r0_blocked", 32'(bad), 0);
    w_valid[0] = 1'b0;
    gnt_log.delete();
    repeat (2) tick();
    chk("fixed_r0_after", (gnt_log.size() > 0) ? 32'(gnt_log[0]) : 32'hFFFF_FFFF, 32'(NW));
    r_addr_valid[0] = 1'b0;
    cfg_mode = 1'b0;
    repeat (3) tick();
    chk("fixed_q_empty", 32'(exp_q0.size()), 0);

    // Backpressure on r0: only two reads may be outstanding.
    r_data_ready[0] = 1'b0;
    r_addr[0 +: AW] = AW'(0);
    r_addr_valid[0] = 1'b1;
    ngr = 0;
    r0_before = rsp_cnt[0];
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      hs = r_addr_ready[0];
      if (hs) ngr++;
      @(posedge clk);
      #1;
      if (hs) r_addr[0 +: AW] = AW'(ngr);
    end
    chk("bp_grants", 32'(ngr), 2);
    chk("bp_no_rsp", 32'(rsp_cnt[0] - r0_before), 0);
    r_data_ready[0] = 1'b1;
    n = 0;
    while (ngr < 6 && n < 50) begin
      @(negedge clk);
      hs = r_addr_ready[0];
      if (hs) ngr++;
      n++;
      @(posedge clk);
      #1;
      if (hs) r_addr[0 +: AW] = AW'(ngr);
    end
    r_addr_valid[0] = 1'b0;
    chk("bp_resume", 32'(ngr), 6);
    repeat (4) tick();
    chk("bp_rsp_cnt", 32'(rsp_cnt[0] - r0_before), 6);

    // Flush one cycle after a read grant discards the in-flight data.
    do_write(0, 200, 16'h1234);
    r_addr[0 +: AW] = AW'(200);
    r_addr_valid[0] = 1'b1;
    hs = 1'b0;
    n  = 0;
    while (!hs && n < 50) begin
      @(negedge clk);
      hs = r_addr_ready[0];
      n++;
      @(posedge clk);
      #1;
    end
    chk("fl_hs", 32'(hs), 1);
    r_addr_valid[0] = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    r0_before = rsp_cnt[0];
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("fl_no_valid", 32'(r_data_valid[0]), 0);
    end
    @(posedge clk);
    #1;
    do_read(0, 200, 1'b1);
    tick();
    chk("fl_rsp_cnt", 32'(rsp_cnt[0] - r0_before), 1);

    // Random traffic on all ports.
    for (int c = 0; c < 200; c++) begin
      w_valid      = NW'($urandom);
      r_addr_valid = NR'($urandom);
      r_data_ready = NR'($urandom);
      w_addr       = {AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31))};
      r_addr       = {AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31))};
      w_data       = {DW'($urandom), DW'($urandom)};
      tick();
    end
    w_valid      = '0;
    r_addr_valid = '0;
    r_data_ready = '1;
    repeat (6) tick();
    chk("rand_q0_empty", 32'(exp_q0.size()), 0);
    chk("rand_q1_empty", 32'(exp_q1.size()), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
